// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: clips drawer coordinates, converts them to linear addresses,
// buffers them in a FIFO and writes them to memory via valid/ready. FB_CLIP_COUNT_EN adds clip_count.
module fb_pixel_writer #(
    parameter int unsigned CORDW  = 16,
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 180,
    parameter int unsigned ADDRW  = 16,
    parameter int unsigned COLRW  = 4,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic                    drawing,
    input  logic [COLRW-1:0]        colr,
    output logic                    oe,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic [ADDRW-1:0]        mem_addr,
    output logic [COLRW-1:0]        mem_data,
    output logic                    idle,
    output logic                    overflow,
    output logic [31:0]             pix_count
`ifdef FB_CLIP_COUNT_EN
    ,
    output logic [31:0]             clip_count
`endif
);

    localparam int unsigned PTRW  = $clog2(DEPTH);
    localparam int unsigned CNTW  = PTRW + 1;
    localparam int unsigned OCCW  = CNTW + 1;
    localparam int unsigned PRODW = 2 * CORDW;
    localparam int unsigned CMPW  = CORDW + 1;

    localparam logic signed [CMPW-1:0] WIDTH_S  = CMPW'(WIDTH);
    localparam logic signed [CMPW-1:0] HEIGHT_S = CMPW'(HEIGHT);

    logic                   stage_valid, stage_valid_d;
    logic [ADDRW-1:0]       stage_addr, stage_addr_d;
    logic [COLRW-1:0]       stage_colr, stage_colr_d;
    logic [PTRW-1:0]        rd_ptr, rd_ptr_d, wr_ptr, wr_ptr_d;
    logic [CNTW-1:0]        count, count_d;
    logic [OCCW-1:0]        occ_d;
    logic                   mem_we_d, oe_d, overflow_d;
    logic [ADDRW-1:0]       mem_addr_d;
    logic [COLRW-1:0]       mem_data_d;
    logic [31:0]            pix_count_d;
    logic                   push, pop, drop, accept, in_bounds;
    logic signed [CMPW-1:0] x_ext, y_ext;

    logic [ADDRW-1:0] fifo_addr [DEPTH];
    logic [COLRW-1:0] fifo_colr [DEPTH];

    // Clip test at one extra bit so WIDTH/HEIGHT never alias to negative values
    assign x_ext     = {x[CORDW-1], x};
    assign y_ext     = {y[CORDW-1], y};
    assign in_bounds = !x_ext[CMPW-1] && !y_ext[CMPW-1] && (x_ext < WIDTH_S) && (y_ext < HEIGHT_S);
    assign accept    = drawing && in_bounds;

    assign idle = (count == '0) && !stage_valid;

    // Next-state: the presented memory word is the FIFO head and stays in the FIFO until popped
    always_comb begin
        pop           = mem_we && mem_ready;
        push          = stage_valid && ((count != CNTW'(DEPTH)) || pop);
        drop          = stage_valid && !push;
        count_d       = count + CNTW'(push) - CNTW'(pop);
        rd_ptr_d      = pop ? rd_ptr + PTRW'(1) : rd_ptr;
        wr_ptr_d      = push ? wr_ptr + PTRW'(1) : wr_ptr;
        stage_valid_d = accept;
        stage_addr_d  = stage_addr;
        stage_colr_d  = stage_colr;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_data_d    = mem_data;
        overflow_d    = overflow || drop;
        pix_count_d   = pix_count + 32'(pop);

        if (accept) begin
            stage_addr_d = ADDRW'(PRODW'($unsigned(y)) * PRODW'(WIDTH) + PRODW'($unsigned(x)));
            stage_colr_d = colr;
        end

        // Entries pushed this edge are not yet readable, so only count - pop are presentable
        if (!mem_we || mem_ready) begin
            mem_we_d = count > CNTW'(pop);
            if (mem_we_d) begin
                mem_addr_d = fifo_addr[rd_ptr_d];
                mem_data_d = fifo_colr[rd_ptr_d];
            end
        end

        occ_d = OCCW'(count_d) + OCCW'(stage_valid_d);
        oe_d  = occ_d <= OCCW'(DEPTH - 3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_colr  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            oe          <= 1'b1;
            overflow    <= 1'b0;
            pix_count   <= '0;
        end else begin
            stage_valid <= stage_valid_d;
            stage_addr  <= stage_addr_d;
            stage_colr  <= stage_colr_d;
            rd_ptr      <= rd_ptr_d;
            wr_ptr      <= wr_ptr_d;
            count       <= count_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_data    <= mem_data_d;
            oe          <= oe_d;
            overflow    <= overflow_d;
            pix_count   <= pix_count_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= stage_addr;
            fifo_colr[wr_ptr] <= stage_colr;
        end
    end

`ifdef FB_CLIP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_count <= '0;
        end else if (drawing && !in_bounds) begin
            clip_count <= clip_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed self-checking bench for fb_pixel_writer: latency, clipping, back-pressure,
// overflow, random memory stalls and asynchronous reset mid-burst.
module tb_fb_pixel_writer;

    localparam int unsigned CORDW = 16;
    localparam int unsigned ADDRW = 16;
    localparam int unsigned COLRW = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic signed [CORDW-1:0] x = '0;
    logic signed [CORDW-1:0] y = '0;
    logic                    drawing = 1'b0;
    logic [COLRW-1:0]        colr = '0;
    logic                    oe;
    logic                    mem_we;
    logic                    mem_ready = 1'b0;
    logic [ADDRW-1:0]        mem_addr;
    logic [COLRW-1:0]        mem_data;
    logic                    idle;
    logic                    overflow;
    logic [31:0]             pix_count;
`ifdef FB_CLIP_COUNT_EN
    logic [31:0]             clip_count;
`endif

    fb_pixel_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .drawing   (drawing),
        .colr      (colr),
        .oe        (oe),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .idle      (idle),
        .overflow  (overflow),
        .pix_count (pix_count)
`ifdef FB_CLIP_COUNT_EN
        ,
        .clip_count(clip_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;
    logic [ADDRW+COLRW-1:0] exp_q [$];
    logic [ADDRW+COLRW-1:0] exp_e;
    logic                   stall_prev = 1'b0;
    logic [ADDRW-1:0]       stall_addr = '0;
    logic [COLRW-1:0]       stall_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write monitor: scoreboard order/content and hold-stability during stalls
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                check("stall_we", 32'(mem_we), 32'd1);
                check("stall_addr", 32'(mem_addr), 32'(stall_addr));
                check("stall_data", 32'(mem_data), 32'(stall_data));
            end
            if (mem_we && mem_ready) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(exp_e[ADDRW+COLRW-1:COLRW]));
                    check("wr_data", 32'(mem_data), 32'(exp_e[COLRW-1:0]));
                end
            end
            stall_prev = mem_we && !mem_ready;
            stall_addr = mem_addr;
            stall_data = mem_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input int px, input int py, input int c, input bit exp_it);
        drawing = 1'b1;
        x       = CORDW'(px);
        y       = CORDW'(py);
        colr    = COLRW'(c);
        if (exp_it) exp_q.push_back({ADDRW'(py * 320 + px), COLRW'(c)});
    endtask

    task automatic put(input int px, input int py, input int c, input bit exp_it);
        drive_pix(px, py, c, exp_it);
        step();
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        drawing   = 1'b0;
        mem_ready = 1'b1;
        while (!(idle && exp_q.size() == 0) && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_done", 32'(idle && exp_q.size() == 0), 32'd1);
    endtask

    task automatic do_reset();
        drawing = 1'b0;
        rst_n   = 1'b0;
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  wr0;
        int  n;
        int  cyc;
        bit  oe_fell;

        step();
        step();
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_oe", 32'(oe), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pix_count", pix_count, 32'd0);
        rst_n = 1'b1;
        step();

        // Single pixel: write appears two edges after sampling
        mem_ready = 1'b1;
        wr0 = wr_count;
        put(10, 5, 3, 1);
        drawing = 1'b0;
        check("lat_n0_we", 32'(mem_we), 32'd0);
        check("lat_n0_idle", 32'(idle), 32'd0);
        step();
        check("lat_n1_we", 32'(mem_we), 32'd0);
        step();
        check("lat_n2_we", 32'(mem_we), 32'd1);
        check("lat_n2_addr", 32'(mem_addr), 32'd1610);
        check("lat_n2_data", 32'(mem_data), 32'd3);
        step();
        check("single_we_off", 32'(mem_we), 32'd0);
        check("single_pix_count", pix_count, 32'd1);
        check("single_idle", 32'(idle), 32'd1);
        check("single_writes", 32'(wr_count - wr0), 32'd1);

        // Clip boundaries: only the last corner pixel survives
        wr0 = wr_count;
        put(-1, 0, 5, 0);
        put(320, 0, 5, 0);
        put(0, 180, 5, 0);
        put(0, -1, 5, 0);
        put(319, 179, 6, 1);
        drawing = 1'b0;
        step();
        step();
        check("clip_we", 32'(mem_we), 32'd1);
        check("clip_addr", 32'(mem_addr), 32'd57599);
        check("clip_data", 32'(mem_data), 32'd6);
        drain(20);
        check("clip_writes", 32'(wr_count - wr0), 32'd1);
        check("clip_pix_count", pix_count, 32'd2);
`ifdef FB_CLIP_COUNT_EN
        check("clip_count", clip_count, 32'd4);
`endif

        // Back-pressure with a drawer that honours oe
        mem_ready = 1'b0;
        wr0 = wr_count;
        n = 0;
        oe_fell = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (!oe) oe_fell = 1'b1;
            if (oe && n < 20) begin
                drive_pix(n, 2, n, 1);
                n++;
            end else begin
                drawing = 1'b0;
            end
            step();
        end
        drawing = 1'b0;
        check("bp_oe_fell", 32'(oe_fell), 32'd1);
        check("bp_oe_low", 32'(oe), 32'd0);
        check("bp_overflow", 32'(overflow), 32'd0);
        check("bp_holding", 32'(mem_we), 32'd1);
        check("bp_no_writes", 32'(wr_count - wr0), 32'd0);
        mem_ready = 1'b1;
        cyc = 0;
        while (n < 20 && cyc < 500) begin
            if (oe) begin
                drive_pix(n, 2, n, 1);
                n++;
            end else begin
                drawing = 1'b0;
            end
            step();
            cyc++;
        end
        check("bp_all_sent", 32'(n), 32'd20);
        drain(100);
        check("bp_writes", 32'(wr_count - wr0), 32'd20);
        check("bp_overflow_end", 32'(overflow), 32'd0);
        check("bp_pix_count", pix_count, 32'd22);

        // Random memory stalls, 1000 pixels, drawer honours oe
        do_reset();
        wr0 = wr_count;
        n = 0;
        cyc = 0;
        while (n < 1000 && cyc < 20000) begin
            mem_ready = 1'($urandom_range(0, 1));
            if (oe) begin
                drive_pix(n % 320, 20 + n / 320, n, 1);
                n++;
            end else begin
                drawing = 1'b0;
            end
            step();
            cyc++;
        end
        check("rnd_all_sent", 32'(n), 32'd1000);
        drain(200);
        check("rnd_writes", 32'(wr_count - wr0), 32'd1000);
        check("rnd_pix_count", pix_count, 32'd1000);
        check("rnd_overflow", 32'(overflow), 32'd0);

        // Overflow: drawer ignores oe; pixels 8..10 dropped, pixel 11 pushed as memory releases
        mem_ready = 1'b0;
        wr0 = wr_count;
        for (int i = 0; i < 12; i++) begin
            put(100 + i, 10, i, (i < 8) || (i == 11));
        end
        drawing = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_oe", 32'(oe), 32'd0);
        check("ovf_idle", 32'(idle), 32'd0);
        drain(50);
        check("ovf_writes", 32'(wr_count - wr0), 32'd9);
        check("ovf_pix_count", pix_count, 32'd1009);
        step();
        step();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Asynchronous reset with five pixels buffered
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) put(i, 7, 9, 1);
        drawing = 1'b0;
        step();
        step();
        check("mid_busy_idle", 32'(idle), 32'd0);
        check("mid_busy_we", 32'(mem_we), 32'd1);
        wr0 = wr_count;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_idle", 32'(idle), 32'd1);
        check("mid_rst_oe", 32'(oe), 32'd1);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_pix_count", pix_count, 32'd0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (10) step();
        check("mid_no_stale", 32'(wr_count - wr0), 32'd0);
        check("mid_pix_count", pix_count, 32'd0);
        check("mid_idle", 32'(idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Consumer end of the drawing-coordinate interface: accepts the x, y and drawing stream from any draw_* module.
- Clips each coordinate to the framebuffer bounds and converts it to a linear address.
- Buffers accepted pixels in a small FIFO and issues them to framebuffer memory with a valid/ready write handshake.
- Drives oe back to the drawer, so drawing throttles when memory stalls.

Parameters:
- CORDW, 16, signed coordinate width (matches drawer).
- WIDTH, 320, framebuffer width in pixels.
- HEIGHT, 180, framebuffer height in pixels.
- ADDRW, 16, memory address width; must hold WIDTH*HEIGHT-1.
- COLRW, 4, colour width in bits.
- DEPTH, 8, FIFO entries; power of two, minimum 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- x  in  CORDW signed  pixel x from drawer
- y  in  CORDW signed  pixel y from drawer
- drawing  in  1  x/y/colr valid this cycle
- colr  in  COLRW  pixel colour
- oe  out  1  output enable to drawer
- mem_we  out  1  write request (valid)
- mem_ready  in  1  memory accepts request this cycle
- mem_addr  out  ADDRW  write address
- mem_data  out  COLRW  write data
- idle  out  1  no pixel in flight
- overflow  out  1  sticky: a pixel was dropped
- pix_count  out  32  pixels written to memory

Behaviour:
- Reset (rst_n low, asynchronous): all outputs take reset values immediately.
  - FIFO and stage are flushed.
  - mem_we=0, mem_addr=0, mem_data=0.
  - oe=1, idle=1, overflow=0, pix_count=0.
  - Reset mid-burst discards all buffered pixels.
- Stage A (input): on each clk edge with drawing=1, apply the clip test.
  - Rejected if x<0, x>=WIDTH, y<0 or y>=HEIGHT. Signed compare at CORDW+1 bits.
  - A rejected pixel is discarded; it causes no write and is not counted.
  - An accepted pixel loads the stage register with addr=y*WIDTH+x (computed at CORDW*2 bits, truncated to ADDRW) and colr, and sets stage_valid.
  - A cycle with drawing=0 clears stage_valid.
- Stage B (push): stage_valid=1 pushes {addr, colr} into the FIFO on the next edge.
  - If the FIFO is full and not popping that cycle, the pixel is dropped and overflow is set.
  - overflow stays set until reset.
- Memory side: mem_we=1 whenever the FIFO is non-empty.
  - mem_addr and mem_data are registered from the FIFO head and held stable while mem_we=1 and mem_ready=0.
  - A pop occurs on an edge where mem_we=1 and mem_ready=1; the next entry is presented on the following cycle (no bubble).
  - Simultaneous push and pop on a full FIFO is legal and never counts as overflow.
  - Occupancy never exceeds DEPTH.
- Latency, mem_ready=1 and FIFO empty: a pixel sampled at edge N gives mem_we=1 with valid addr/data after edge N+2. One write per cycle sustained.
- oe is registered:
  - It is high for the next cycle iff free = DEPTH - count - stage_valid >= 3, evaluated from next-state values.
  - This leaves room for one pixel in stage A and one more presented after oe falls.
  - A drawer honouring oe with at most one cycle of latency can never cause overflow.
- pix_count increments on each pop and wraps at 2^32.
- idle = FIFO empty and stage_valid=0. It is combinational from registers.

Optional Feature:
- Macro FB_CLIP_COUNT_EN.
- Defined: adds output port clip_count (32 bits).
  - Reset value 0; wraps at 2^32.
  - Increments once for each sampled drawing=1 pixel rejected by the clip test.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Single pixel (10,5), colr=3, mem_ready=1 -> exactly one mem_we cycle, 2 cycles after sample, mem_addr=1610, mem_data=3; pix_count=1; idle returns to 1.
- Clip boundaries: (-1,0), (320,0), (0,180), (0,-1), (319,179) -> one write only, addr 57599; with FB_CLIP_COUNT_EN, clip_count=4.
- Back-pressure: mem_ready=0 while a drawer honouring oe streams 20 pixels (x=0..19, y=2) -> oe falls and overflow stays 0. Releasing mem_ready then gives 20 writes, addr 640..659 in order, addr/data stable during stall cycles.
- Overflow: drawing=1 for 12 consecutive cycles, oe ignored, mem_ready=0 -> 8 FIFO + 1 stage held, overflow=1. After release exactly 9 writes; overflow stays 1 until reset.
- Random mem_ready (50%) with continuous drawing honouring oe, 1000 pixels -> writes in order, no loss, pix_count=1000, overflow=0.
- Reset mid-burst: assert rst_n low asynchronously between edges with 5 pixels buffered -> mem_we=0 and idle=1 before the next edge; after release no stale writes, pix_count=0.
